// File: rtl/flash_pkg.sv
// Shared definitions for the parallel-flash program/erase path.
// Command codes, op and state encodings, register map, timing helper.
// No logic; imported by the bus-cycle engine and the Wishbone top.
package flash_pkg;

    localparam logic [7:0] CMD_ERASE_SETUP = 8'h20;
    localparam logic [7:0] CMD_PROG_SETUP  = 8'h40;
    localparam logic [7:0] CMD_CLR_SR      = 8'h50;
    localparam logic [7:0] CMD_LOCK_SETUP  = 8'h60;
    localparam logic [7:0] CMD_READ_SR     = 8'h70;
    localparam logic [7:0] CMD_CONFIRM     = 8'hD0;
    localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;

    // Status bits that indicate a failed operation (erase, program, Vpp, lock).
    localparam logic [7:0] SR_ERR_MASK = 8'h3A;

    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    typedef enum logic [1:0] {OP_NOP, OP_PROG, OP_ERASE, OP_UNLOCK} op_t;
    typedef enum logic [1:0] {BUS_WR, BUS_RD, BUS_GAP} bus_op_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD1, ST_CMD2, ST_POLL_RD, ST_POLL_GAP, ST_CLR, ST_ARRAY
    } state_t;

    function automatic int ns_to_cycles(input int ns, input int mhz);
        int c;
        c = (ns * mhz + 999) / 1000;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One timed flash bus cycle: write (we_n low WP), read (oe_n low OE) or idle gap, each followed by WH high.
// Strobes follow start by one cycle; done is high in the final recovery cycle so the next cycle can chain without a gap.
// No backpressure: start is accepted only when idle or in the done cycle.
module flash_bus_cycle
    import flash_pkg::*;
#(
    parameter int WP_CYC = 5,
    parameter int WH_CYC = 3,
    parameter int OE_CYC = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  bus_op_t     op,
    input  logic [15:0] din,
    output logic        ce_n,
    output logic        oe_n,
    output logic        we_n,
    output logic        dout_en,
    output logic        active,
    output logic        done,
    output logic [7:0]  rd_dat
);

    localparam int CW = 8;

    typedef enum logic [1:0] {PH_IDLE, PH_ACT, PH_REC} phase_t;

    phase_t        phase;
    bus_op_t       op_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] act_last;
    logic          din_hi_unused;

    assign din_hi_unused = ^din[15:8];
    assign act_last = (op_q == BUS_RD) ? CW'(OE_CYC - 1) : CW'(WP_CYC - 1);
    assign done     = (phase == PH_REC) && (cnt == CW'(WH_CYC - 1));
    assign active   = (phase != PH_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase  <= PH_IDLE;
            op_q   <= BUS_GAP;
            cnt    <= '0;
            rd_dat <= '0;
        end else if (start && (phase == PH_IDLE || done)) begin
            op_q  <= op;
            cnt   <= '0;
            phase <= (op == BUS_GAP) ? PH_REC : PH_ACT;
        end else begin
            case (phase)
                PH_ACT: begin
                    // Status is sampled on the last oe_n-low cycle, after full output settling.
                    if (op_q == BUS_RD && cnt == act_last)
                        rd_dat <= din[7:0];
                    if (cnt == act_last) begin
                        phase <= PH_REC;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PH_REC: begin
                    if (done)
                        phase <= PH_IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ce_n    = 1'b1;
        oe_n    = 1'b1;
        we_n    = 1'b1;
        dout_en = 1'b0;
        if (phase == PH_ACT) begin
            ce_n = 1'b0;
            we_n = (op_q != BUS_WR);
            oe_n = (op_q != BUS_RD);
        end
        // Keep driving the data bus through recovery so it holds past the we_n rise.
        if (phase != PH_IDLE && op_q == BUS_WR)
            dout_en = 1'b1;
    end

endmodule

// File: rtl/wb_flash_programmer.sv
// Wishbone-controlled program/erase/unlock sequencer for a 16-bit Intel/Micron-command flash.
// First we_n fall one cycle after the CTRL ack; register ack one cycle after cyc&stb.
// No backpressure: register writes while busy are acked and dropped; polling waits on the device indefinitely.
module wb_flash_programmer
    import flash_pkg::*;
#(
    parameter int CLK_FREQ  = 100,
    parameter int ADDR_BITS = 25,
    parameter int T_WP_NS   = 50,
    parameter int T_WH_NS   = 30,
    parameter int T_OE_NS   = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 flash_busy,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:2]           wbs_addr_i,
    input  logic [31:0]          wbs_data_i,
    output logic [31:0]          wbs_data_o,
    output logic                 wbs_ack_o,
    output logic                 flash_ce_n,
    output logic                 flash_oe_n,
    output logic                 flash_we_n,
    output logic                 flash_rst_n,
    output logic                 flash_wp_n,
    input  logic                 flash_ready,
    output logic [ADDR_BITS-1:1] flash_addr,
    input  logic [15:0]          flash_din,
    output logic [15:0]          flash_dout,
    output logic                 flash_dout_en
);

    localparam int WP_CYC = ns_to_cycles(T_WP_NS, CLK_FREQ);
    localparam int WH_CYC = ns_to_cycles(T_WH_NS, CLK_FREQ);
    localparam int OE_CYC = ns_to_cycles(T_OE_NS, CLK_FREQ);

    state_t               state, state_nxt;
    op_t                  op_q;
    logic [ADDR_BITS-1:1] addr_q;
    logic [15:0]          data_q;
    logic                 done_q, err_q, kick;
    logic                 wb_req, wb_served, wb_acc, wb_wr, idle, launch;
    logic [31:0]          rd_mux;
    logic                 bus_start, bus_done;
    bus_op_t              bus_op;
    logic [7:0]           bus_rd_dat;
    logic                 wb_dat_unused;

    assign wb_dat_unused = ^wbs_data_i[31:ADDR_BITS];

    assign idle   = (state == ST_IDLE);
    assign wb_req = wbs_cyc_i & wbs_stb_i;
    // One ack per strobe: wb_served blocks re-acking while the master holds stb.
    assign wb_acc = wb_req & ~wbs_ack_o & ~wb_served;
    assign wb_wr  = wb_acc & wbs_we_i & idle;
    assign launch = wb_wr && (wbs_addr_i == REG_CTRL) && (wbs_data_i[1:0] != 2'b00);

    always_comb begin
        rd_mux = '0;
        case (wbs_addr_i)
            REG_ADDR:   rd_mux[ADDR_BITS-1:1] = addr_q;
            REG_DATA:   rd_mux[15:0] = data_q;
            REG_STATUS: begin
                rd_mux[0]    = flash_busy;
                rd_mux[1]    = done_q;
                rd_mux[2]    = err_q;
                rd_mux[15:8] = bus_rd_dat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wbs_ack_o   <= 1'b0;
            wb_served   <= 1'b0;
            wbs_data_o  <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= OP_NOP;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            kick        <= 1'b0;
            flash_rst_n <= 1'b0;
        end else begin
            flash_rst_n <= 1'b1;
            wbs_ack_o   <= wb_acc;
            wb_served   <= wb_req & (wb_served | wbs_ack_o);
            kick        <= launch;
            if (wb_acc && !wbs_we_i)
                wbs_data_o <= rd_mux;
            if (wb_wr) begin
                case (wbs_addr_i)
                    REG_ADDR: addr_q <= wbs_data_i[ADDR_BITS-1:1];
                    REG_DATA: data_q <= wbs_data_i[15:0];
                    REG_CTRL: begin
                        op_q   <= op_t'(wbs_data_i[1:0]);
                        done_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state == ST_ARRAY && bus_done) begin
                done_q <= 1'b1;
                err_q  <= |(bus_rd_dat & SR_ERR_MASK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (launch) state_nxt = ST_CMD1;
            ST_CMD1:     if (bus_done) state_nxt = ST_CMD2;
            ST_CMD2:     if (bus_done) state_nxt = (op_q == OP_UNLOCK) ? ST_ARRAY : ST_POLL_RD;
            ST_POLL_RD:  if (bus_done) state_nxt = (bus_rd_dat[7] && flash_ready) ? ST_CLR : ST_POLL_GAP;
            ST_POLL_GAP: if (bus_done) state_nxt = ST_POLL_RD;
            ST_CLR:      if (bus_done) state_nxt = ST_ARRAY;
            ST_ARRAY:    if (bus_done) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        // kick launches the first cycle; later cycles chain off the previous cycle's done.
        bus_start = kick | (bus_done & (state_nxt != ST_IDLE));
        bus_op    = BUS_WR;
        if (state_nxt == ST_POLL_RD)
            bus_op = BUS_RD;
        else if (state_nxt == ST_POLL_GAP)
            bus_op = BUS_GAP;
        flash_dout = '0;
        case (state)
            ST_CMD1: begin
                case (op_q)
                    OP_PROG:  flash_dout = {8'h00, CMD_PROG_SETUP};
                    OP_ERASE: flash_dout = {8'h00, CMD_ERASE_SETUP};
                    default:  flash_dout = {8'h00, CMD_LOCK_SETUP};
                endcase
            end
            ST_CMD2:  flash_dout = (op_q == OP_PROG) ? data_q : {8'h00, CMD_CONFIRM};
            ST_CLR:   flash_dout = {8'h00, CMD_CLR_SR};
            ST_ARRAY: flash_dout = {8'h00, CMD_READ_ARRAY};
            default:  ;
        endcase
    end

    flash_bus_cycle #(
        .WP_CYC (WP_CYC),
        .WH_CYC (WH_CYC),
        .OE_CYC (OE_CYC)
    ) u_bus (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (bus_start),
        .op      (bus_op),
        .din     (flash_din),
        .ce_n    (flash_ce_n),
        .oe_n    (flash_oe_n),
        .we_n    (flash_we_n),
        .dout_en (flash_dout_en),
        .active  (flash_busy),
        .done    (bus_done),
        .rd_dat  (bus_rd_dat)
    );

    assign flash_addr = addr_q;
    assign flash_wp_n = flash_busy;

endmodule

// File: tb/tb_wb_flash_programmer.sv
// Scoreboard bench: expected flash writes, read data and busy lengths are queued by stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_wb_flash_programmer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [3:2]  wb_adr;
    logic [31:0] wb_dat;

    logic        busy0, ack0, ce0, oe0, we0, frst0, wp0, doen0, ready0;
    logic [31:0] dato0;
    logic [24:1] addr0;
    logic [15:0] dout0, din0;
    logic [7:0]  cur_sr;
    assign din0 = {8'h00, cur_sr};

    logic        busy1_unused, ack1_unused, ce1_unused, frst1_unused, wp1_unused, doen1_unused;
    logic        oe1, we1;
    logic [31:0] dato1_unused;
    logic [24:1] addr1_unused;
    logic [15:0] dout1_unused;

    wb_flash_programmer dut0 (
        .clk(clk), .rst_n(rst_n), .flash_busy(busy0),
        .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we), .wbs_addr_i(wb_adr),
        .wbs_data_i(wb_dat), .wbs_data_o(dato0), .wbs_ack_o(ack0),
        .flash_ce_n(ce0), .flash_oe_n(oe0), .flash_we_n(we0), .flash_rst_n(frst0),
        .flash_wp_n(wp0), .flash_ready(ready0), .flash_addr(addr0), .flash_din(din0),
        .flash_dout(dout0), .flash_dout_en(doen0)
    );

    wb_flash_programmer #(.CLK_FREQ(33)) dut1 (
        .clk(clk), .rst_n(rst_n), .flash_busy(busy1_unused),
        .wbs_cyc_i(wb_cyc), .wbs_stb_i(wb_stb), .wbs_we_i(wb_we), .wbs_addr_i(wb_adr),
        .wbs_data_i(wb_dat), .wbs_data_o(dato1_unused), .wbs_ack_o(ack1_unused),
        .flash_ce_n(ce1_unused), .flash_oe_n(oe1), .flash_we_n(we1), .flash_rst_n(frst1_unused),
        .flash_wp_n(wp1_unused), .flash_ready(1'b1), .flash_addr(addr1_unused), .flash_din(16'h0080),
        .flash_dout(dout1_unused), .flash_dout_en(doen1_unused)
    );

    typedef struct packed { logic [23:0] a; logic [15:0] d; } wr_t;
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    int          exp_busy[$];
    logic [7:0]  sr_rest[$];
    int          ready_after = 0;
    int          poll_cnt = 0;
    int          n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: pulse widths, flash write contents, busy lengths, Wishbone read data.
    int we_len0 = 0, oe_len0 = 0, we_len1 = 0, oe_len1 = 0, busy_len0 = 0;
    logic [23:0] cap_a;
    logic [15:0] cap_d;
    logic        wr_bad;
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            we_len0 = 0; oe_len0 = 0; we_len1 = 0; oe_len1 = 0; busy_len0 = 0;
        end else begin
            if (!we0) begin
                if (we_len0 == 0) begin cap_a = addr0; cap_d = dout0; wr_bad = 1'b0; end
                else if (addr0 !== cap_a || dout0 !== cap_d) wr_bad = 1'b1;
                if (!doen0 || ce0) wr_bad = 1'b1;
                we_len0++;
            end else if (we_len0 != 0) begin
                if (exp_wr.size() == 0) fail_now("flash_write_unexpected");
                else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("flash_write", {wr_bad, cap_a, cap_d}, {1'b0, e.a, e.d});
                end
                check("we_low_100", we_len0, 5);
                we_len0 = 0;
            end
            if (!oe0) begin
                if (oe_len0 == 0) begin poll_cnt++; ready0 = (poll_cnt > ready_after); end
                oe_len0++;
            end else if (oe_len0 != 0) begin
                check("oe_low_100", oe_len0, 10);
                oe_len0 = 0;
                if (sr_rest.size() > 0) cur_sr = sr_rest.pop_front();
            end
            if (!we1) we_len1++;
            else if (we_len1 != 0) begin check("we_low_33", we_len1, 2); we_len1 = 0; end
            if (!oe1) oe_len1++;
            else if (oe_len1 != 0) begin check("oe_low_33", oe_len1, 4); oe_len1 = 0; end
            if (busy0) busy_len0++;
            else if (busy_len0 != 0) begin
                if (exp_busy.size() == 0) fail_now("busy_unexpected");
                else check("busy_len", busy_len0, exp_busy.pop_front());
                busy_len0 = 0;
            end
            if (ack0 && !wb_we) begin
                if (exp_rd.size() == 0) fail_now("wb_read_unexpected");
                else check("wb_read", dato0, exp_rd.pop_front());
            end
        end
    end

    task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = w; wb_adr = a; wb_dat = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!ack0 && n < 20);
        if (!ack0) fail_now("wb_ack_timeout");
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, input logic [31:0] exp);
        exp_rd.push_back(exp);
        wb_xfer(1'b0, a, 32'h0);
    endtask

    task automatic wait_idle();
        int n;
        repeat (2) @(negedge clk);
        n = 0;
        while (busy0 && n < 2000) begin @(negedge clk); n++; end
        if (busy0) fail_now("busy_timeout");
        @(negedge clk);
    endtask

    task automatic push_wr(input logic [15:0] d);
        wr_t e;
        e.a = 24'h000080;
        e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic set_sr(input logic [7:0] first);
        cur_sr = first;
        sr_rest.delete();
        poll_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int acks, n;
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 2'd0; wb_dat = '0;
        ready0 = 1'b1; cur_sr = 8'h80;
        repeat (3) @(negedge clk);
        check("reset_strobes", {ce0, oe0, we0, frst0, wp0, doen0, ack0, busy0}, 8'b1110_0000);
        check("reset_data", {dout0, addr0, dato0}, 72'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // STATUS after reset, with stb held: exactly one ack
        exp_rd.push_back(32'h0);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd3;
        acks = 0;
        repeat (5) begin @(negedge clk); if (ack0) acks++; end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        check("ack_single", acks, 1);

        // Program
        wb_xfer(1'b1, 2'd0, 32'h100);
        wb_xfer(1'b1, 2'd1, 32'hBEEF);
        wb_read(2'd0, 32'h100);
        wb_read(2'd1, 32'hBEEF);
        set_sr(8'h80); ready_after = 0;
        push_wr(16'h0040); push_wr(16'hBEEF); push_wr(16'h0050); push_wr(16'h00FF);
        exp_busy.push_back(45);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 2'd2; wb_dat = 32'h1;
        @(negedge clk);
        check("ctrl_ack", ack0, 1'b1);
        check("busy_at_ack", {busy0, we0, wp0}, 3'b010);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check("busy_first_we", {busy0, we0, wp0}, 3'b101);
        wait_idle();
        check("prog_polls", poll_cnt, 1);
        wb_read(2'd3, 32'h8002);

        // Erase: three not-ready polls then SR=0xA0
        set_sr(8'h00);
        sr_rest.push_back(8'h00); sr_rest.push_back(8'h00); sr_rest.push_back(8'hA0);
        push_wr(16'h0020); push_wr(16'h00D0); push_wr(16'h0050); push_wr(16'h00FF);
        exp_busy.push_back(93);
        wb_xfer(1'b1, 2'd2, 32'h2);
        wait_idle();
        check("erase_polls", poll_cnt, 4);
        wb_read(2'd3, 32'hA006);

        // Unlock: no polling
        set_sr(8'h80);
        push_wr(16'h0060); push_wr(16'h00D0); push_wr(16'h00FF);
        exp_busy.push_back(24);
        wb_xfer(1'b1, 2'd2, 32'h3);
        wait_idle();
        check("unlock_polls", poll_cnt, 0);
        wb_read(2'd3, 32'hA006);

        // Program with ready low on the first poll; register writes while busy are dropped
        set_sr(8'h80); sr_rest.push_back(8'h80); ready_after = 1;
        push_wr(16'h0040); push_wr(16'hBEEF); push_wr(16'h0050); push_wr(16'h00FF);
        exp_busy.push_back(61);
        wb_xfer(1'b1, 2'd2, 32'h1);
        wb_xfer(1'b1, 2'd1, 32'h1234);
        wb_xfer(1'b1, 2'd2, 32'h2);
        wb_xfer(1'b1, 2'd0, 32'h200);
        wait_idle();
        ready_after = 0;
        check("busy_wr_polls", poll_cnt, 2);
        wb_read(2'd1, 32'hBEEF);
        wb_read(2'd0, 32'h100);
        wb_read(2'd3, 32'h8002);

        // Reset in the middle of polling
        set_sr(8'h00);
        push_wr(16'h0040); push_wr(16'hBEEF);
        wb_xfer(1'b1, 2'd2, 32'h1);
        n = 0;
        while (oe0 && n < 200) begin @(negedge clk); n++; end
        if (oe0) fail_now("poll_start_timeout");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid_poll", {ce0, oe0, we0, frst0, busy0}, 5'b11100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        wb_read(2'd3, 32'h0);
        wb_read(2'd0, 32'h0);
        wb_read(2'd1, 32'h0);

        repeat (30) @(negedge clk);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("busy_queue_drained", exp_busy.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
